// File: rtl/serial_byte_collector.sv
// Serial frame collector: waits for a start marker, shifts in WIDTH data bits on
// bit_en strobes, and hands each finished word to a valid/ready output register.
module serial_byte_collector #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_d_in,
  input  logic             i_bit_en,
  input  logic             i_byte_ready,
  output logic [WIDTH-1:0] o_byte_out,
  output logic             o_byte_valid,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_next_word;

  // Shift register contents including the bit sampled this cycle.
  always_comb begin
    w_next_word = '0;
    if (MSB_FIRST) w_next_word = {r_shift[WIDTH-2:0], i_d_in};
    else           w_next_word = {i_d_in, r_shift[WIDTH-1:1]};
  end

  // Output handshake: a word moves downstream on every cycle where
  // o_byte_valid & i_byte_ready; o_byte_out is held constant while o_byte_valid=1.
  // A frame completing while an unaccepted word is held is dropped with o_overrun.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      o_byte_out   <= '0;
      o_byte_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (o_byte_valid && i_byte_ready) o_byte_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_bit_en && i_d_in) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (i_bit_en) begin
            r_shift <= w_next_word;
            if (r_cnt == LAST_BIT) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              o_busy  <= 1'b0;
              if (!o_byte_valid || i_byte_ready) begin
                o_byte_out   <= w_next_word;
                o_byte_valid <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_collector.sv
// Bench for serial_byte_collector: directed scenarios plus a randomized run,
// two instances (MSB-first and LSB-first) checked against a frame-level model.
module tb_serial_byte_collector;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         d_in;
  logic         bit_en;
  logic         rdy;
  logic [W-1:0] out_m, out_l;
  logic         valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;

  int checks = 0;
  int errors = 0;

  serial_byte_collector #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .i_clk(clk), .i_rst(rst), .i_d_in(d_in), .i_bit_en(bit_en), .i_byte_ready(rdy),
    .o_byte_out(out_m), .o_byte_valid(valid_m), .o_busy(busy_m), .o_overrun(ovr_m)
  );

  serial_byte_collector #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .i_clk(clk), .i_rst(rst), .i_d_in(d_in), .i_bit_en(bit_en), .i_byte_ready(rdy),
    .o_byte_out(out_l), .o_byte_valid(valid_l), .o_busy(busy_l), .o_overrun(ovr_l)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: frame-level view, collected bits kept in a queue.
  bit           m_in_frame = 1'b0;
  bit           m_bits[$];
  bit           m_done;
  logic [W-1:0] m_word_m = '0, m_word_l = '0;
  logic         m_valid = 1'b0, m_ovr = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in_frame = 1'b0;
      m_bits.delete();
      m_word_m = '0;
      m_word_l = '0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
    end else begin
      m_done = 1'b0;
      m_ovr  = 1'b0;
      if (bit_en) begin
        if (!m_in_frame) begin
          if (d_in) begin
            m_in_frame = 1'b1;
            m_bits.delete();
          end
        end else begin
          m_bits.push_back(d_in);
          if (m_bits.size() == W) begin
            m_done     = 1'b1;
            m_in_frame = 1'b0;
          end
        end
      end
      if (m_done) begin
        if (!m_valid || rdy) begin
          for (int i = 0; i < W; i++) begin
            m_word_m[W-1-i] = m_bits[i];
            m_word_l[i]     = m_bits[i];
          end
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
  end

  // Valid-word monitor used by the mid-frame reset scenario
  int           vcount = 0;
  logic [W-1:0] vlast  = '0;
  always @(negedge clk) begin
    if (valid_m === 1'b1) begin
      vcount++;
      vlast = out_m;
    end
  end

  // Driver tasks (called at a negedge)
  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      bit_en = 1'b0;
      d_in   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bit_en = 1'b1;
    d_in   = b;
    @(negedge clk);
    bit_en = 1'b0;
    d_in   = 1'($urandom_range(0, 1));
  endtask

  task automatic send_partial(input logic [W-1:0] word, input int nbits, input int maxgap);
    send_bit(1'b1, $urandom_range(0, maxgap));
    for (int i = W - 1; i >= W - nbits; i--) send_bit(word[i], $urandom_range(0, maxgap));
  endtask

  task automatic send_frame(input logic [W-1:0] word, input int maxgap);
    send_partial(word, W, maxgap);
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1; bit_en = 1'b0; d_in = 1'b0; rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(8'h96, 0);
    send_partial(8'h00, 3, 0);
    checks++;
    if ({valid_m, busy_m, out_m} !== {1'b1, 1'b1, 8'h96}) begin
      errors++;
      $display("FAIL pre_reset: valid=%b busy=%b out=%h expected 1 1 96", valid_m, busy_m, out_m);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({valid_m, busy_m, ovr_m, out_m} !== '0) begin
      errors++;
      $display("FAIL reset_msb: valid=%b busy=%b ovr=%b out=%h expected all 0", valid_m, busy_m, ovr_m, out_m);
    end
    checks++;
    if ({valid_l, busy_l, ovr_l, out_l} !== '0) begin
      errors++;
      $display("FAIL reset_lsb: valid=%b busy=%b ovr=%b out=%h expected all 0", valid_l, busy_l, ovr_l, out_l);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({valid_m, busy_m} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_idle: valid=%b busy=%b expected 0 0", valid_m, busy_m);
    end
  endtask

  task automatic test_basic();
    rdy = 1'b1;
    send_bit(1'b1, 0);
    checks++;
    if (busy_m !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy=%b expected 1", busy_m);
    end
    for (int i = W - 1; i >= 0; i--) send_bit(8'hA5 >> i, 0);
    checks++;
    if ({valid_m, out_m, busy_m, ovr_m} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_word: valid=%b out=%h busy=%b ovr=%b expected 1 a5 0 0", valid_m, out_m, busy_m, ovr_m);
    end
    checks++;
    if ({valid_l, out_l} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL basic_lsb_word: valid=%b out=%h expected 1 a5", valid_l, out_l);
    end
    @(negedge clk);
    checks++;
    if ({valid_m, valid_l} !== 2'b00) begin
      errors++;
      $display("FAIL basic_drop: valid_m=%b valid_l=%b expected 0 0", valid_m, valid_l);
    end
  endtask

  task automatic test_bit_order();
    rdy = 1'b1;
    send_frame(8'h01, 0);
    checks++;
    if ({out_m, out_l} !== {8'h01, 8'h80}) begin
      errors++;
      $display("FAIL bit_order: msb_out=%h lsb_out=%h expected 01 80", out_m, out_l);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    rdy = 1'b0;
    send_frame(8'h3C, 1);
    checks++;
    if ({valid_m, out_m, ovr_m} !== {1'b1, 8'h3C, 1'b0}) begin
      errors++;
      $display("FAIL bp_first: valid=%b out=%h ovr=%b expected 1 3c 0", valid_m, out_m, ovr_m);
    end
    send_partial(8'hC3, W - 1, 1);
    checks++;
    if (ovr_m !== 1'b0) begin
      errors++;
      $display("FAIL bp_early_ovr: ovr=%b expected 0", ovr_m);
    end
    send_bit(1'b1, 0);
    checks++;
    if ({valid_m, out_m, ovr_m, ovr_l} !== {1'b1, 8'h3C, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL bp_overrun: valid=%b out=%h ovr_m=%b ovr_l=%b expected 1 3c 1 1", valid_m, out_m, ovr_m, ovr_l);
    end
    @(negedge clk);
    checks++;
    if ({ovr_m, valid_m, out_m} !== {1'b0, 1'b1, 8'h3C}) begin
      errors++;
      $display("FAIL bp_ovr_pulse: ovr=%b valid=%b out=%h expected 0 1 3c", ovr_m, valid_m, out_m);
    end
    rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_m !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: valid=%b expected 0", valid_m);
    end
  endtask

  task automatic test_back_to_back_accept();
    rdy = 1'b0;
    send_frame(8'h11, 0);
    send_partial(8'h22, W - 1, 0);
    checks++;
    if ({valid_m, out_m} !== {1'b1, 8'h11}) begin
      errors++;
      $display("FAIL sim_hold: valid=%b out=%h expected 1 11", valid_m, out_m);
    end
    rdy = 1'b1;
    send_bit(1'b0, 0);
    checks++;
    if ({valid_m, out_m, ovr_m} !== {1'b1, 8'h22, 1'b0}) begin
      errors++;
      $display("FAIL sim_load: valid=%b out=%h ovr=%b expected 1 22 0", valid_m, out_m, ovr_m);
    end
    checks++;
    if (out_l !== 8'h44) begin
      errors++;
      $display("FAIL sim_load_lsb: out=%h expected 44", out_l);
    end
    @(negedge clk);
    checks++;
    if (valid_m !== 1'b0) begin
      errors++;
      $display("FAIL sim_drop: valid=%b expected 0", valid_m);
    end
  endtask

  task automatic test_midframe_reset();
    rdy = 1'b1;
    send_partial(8'hFF, 4, 3);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy_m !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_busy: busy=%b expected 0", busy_m);
    end
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    send_frame(8'h5A, 5);
    repeat (4) @(negedge clk);
    checks++;
    if (vcount !== 1 || vlast !== 8'h5A) begin
      errors++;
      $display("FAIL mid_reset_output: words=%0d last=%h expected 1 5a", vcount, vlast);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if ({valid_m, out_m, busy_m, ovr_m} !== {m_valid, m_word_m, m_in_frame, m_ovr} ||
          {valid_l, out_l, busy_l, ovr_l} !== {m_valid, m_word_l, m_in_frame, m_ovr}) begin
        errors++;
        $display("FAIL random_cycle%0d: msb v=%b o=%h b=%b ov=%b lsb v=%b o=%h b=%b ov=%b expected v=%b m=%h l=%h b=%b ov=%b",
                 c, valid_m, out_m, busy_m, ovr_m, valid_l, out_l, busy_l, ovr_l,
                 m_valid, m_word_m, m_word_l, m_in_frame, m_ovr);
      end
      bit_en = ($urandom_range(0, 3) != 0);
      d_in   = 1'($urandom_range(0, 1));
      rdy    = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    bit_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bit_order();
    test_backpressure();
    test_back_to_back_accept();
    test_midframe_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
